// File: rtl/mode_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_counter_pkg
// Purpose  : Shared end-of-range mode encodings for the mode counter.
// Revision : 1.0
// ============================================================================
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

endpackage : mode_counter_pkg
`default_nettype wire

// File: rtl/mc_next.sv
`default_nettype none
// ============================================================================
// Module   : mc_next
// Purpose  : Next-count logic: load clamp, direction, terminal detect, wrap/sat.
// Revision : 1.0
// ============================================================================
module mc_next
    import mode_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             done,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q_next,
    output logic             done_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_term;
    logic             w_at_term;
    logic [WIDTH-1:0] w_din_clamped;
    logic             w_oneshot_stalled;
    mode_e            w_mode;

    assign w_mode            = mode_e'(mode);
    assign w_term            = up ? C_MAX : '0;
    assign w_at_term         = (q == w_term);
    assign tc                = en & w_at_term;
    assign w_din_clamped     = (32'(din) >= MODULUS) ? C_MAX : din;
    // A finished one-shot only freezes the count while ONESHOT is still selected.
    assign w_oneshot_stalled = done && (w_mode == MODE_ONESHOT);

    always_comb begin
        q_next    = q;
        done_next = done;
        if (load) begin
            q_next    = w_din_clamped;
            done_next = 1'b0;
        end else if (en && !w_oneshot_stalled) begin
            if (!w_at_term) begin
                q_next = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
            end else begin
                case (w_mode)
                    MODE_SAT:     q_next    = q;
                    MODE_ONESHOT: done_next = 1'b1;
                    default:      q_next    = up ? '0 : C_MAX;
                endcase
            end
        end
    end

endmodule : mc_next
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// Module   : mode_counter
// Purpose  : Modulo up/down counter with wrap, saturate and one-shot modes.
// Revision : 1.0
// ============================================================================
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic             r_done;
    logic [WIDTH-1:0] w_q_next;
    logic             w_done_next;

    mc_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mc_next (
        .q         (r_q),
        .done      (r_done),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .load      (load),
        .din       (din),
        .q_next    (w_q_next),
        .done_next (w_done_next),
        .tc        (tc)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_q    <= '0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_done <= w_done_next;
        end
    end

    assign Q    = r_q;
    assign Qb   = ~r_q;
    assign done = r_done;

endmodule : mode_counter
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_counter
// Purpose  : Directed-vector scoreboard bench for mode_counter (WIDTH=4, MODULUS=10).
// Revision : 1.0
// ============================================================================
module tb_mode_counter;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] Q;
    logic [3:0] Qb;
    logic       tc;
    logic       done;

    typedef struct {
        int         id;
        logic [3:0] q;
        logic       tc;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    always #5 ck = ~ck;

    mode_counter #(
        .WIDTH   (4),
        .MODULUS (10)
    ) dut (
        .ck   (ck),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .mode (mode),
        .load (load),
        .din  (din),
        .Q    (Q),
        .Qb   (Qb),
        .tc   (tc),
        .done (done)
    );

    // Drive one edge's inputs, then record what the DUT must show after that edge.
    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input logic [1:0] m, input logic [3:0] d,
                        input logic [3:0] eq, input logic ed);
        exp_t x;
        @(negedge ck);
        rst = r; load = l; en = e; up = u; mode = m; din = d;
        @(posedge ck);
        x.id   = vec_id;
        x.q    = eq;
        x.done = ed;
        x.tc   = e && (eq == (u ? 4'd9 : 4'd0));
        sb.push_back(x);
        vec_id++;
    endtask

    always @(posedge ck) begin
        #1;
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (Q !== x.q) begin
                errors++;
                $display("FAIL q[%0d]: got %h expected %h", x.id, Q, x.q);
            end
            checks++;
            if (Qb !== ~x.q) begin
                errors++;
                $display("FAIL qb[%0d]: got %h expected %h", x.id, Qb, ~x.q);
            end
            checks++;
            if (tc !== x.tc) begin
                errors++;
                $display("FAIL tc[%0d]: got %b expected %b", x.id, tc, x.tc);
            end
            checks++;
            if (done !== x.done) begin
                errors++;
                $display("FAIL done[%0d]: got %b expected %b", x.id, done, x.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        step(1, 0, 0, 0, 2'b00, 4'h0, 4'd0, 0);
        // WRAP up for 12 edges
        for (int i = 0; i < 12; i++)
            step(0, 0, 1, 1, 2'b00, 4'h0, 4'((i + 1) % 10), 0);
        // hold with en=0
        step(0, 0, 0, 1, 2'b00, 4'h0, 4'd2, 0);
        // load 3 then WRAP down
        step(0, 1, 0, 0, 2'b00, 4'd3, 4'd3, 0);
        step(0, 0, 1, 0, 2'b00, 4'h0, 4'd2, 0);
        step(0, 0, 1, 0, 2'b00, 4'h0, 4'd1, 0);
        step(0, 0, 1, 0, 2'b00, 4'h0, 4'd0, 0);
        step(0, 0, 1, 0, 2'b00, 4'h0, 4'd9, 0);
        step(0, 0, 1, 0, 2'b00, 4'h0, 4'd8, 0);
        // SAT
        step(0, 1, 0, 1, 2'b01, 4'd7, 4'd7, 0);
        step(0, 0, 1, 1, 2'b01, 4'h0, 4'd8, 0);
        step(0, 0, 1, 1, 2'b01, 4'h0, 4'd9, 0);
        step(0, 0, 1, 1, 2'b01, 4'h0, 4'd9, 0);
        step(0, 0, 1, 1, 2'b01, 4'h0, 4'd9, 0);
        step(0, 0, 1, 1, 2'b01, 4'h0, 4'd9, 0);
        step(0, 0, 1, 0, 2'b01, 4'h0, 4'd8, 0);
        // SAT down at 0 holds
        step(0, 1, 0, 0, 2'b01, 4'd0, 4'd0, 0);
        step(0, 0, 1, 0, 2'b01, 4'h0, 4'd0, 0);
        // ONESHOT: load wins over en
        step(0, 1, 1, 1, 2'b10, 4'd8, 4'd8, 0);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd9, 0);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd9, 1);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd9, 1);
        // done set: direction change is ignored, tc follows current up
        step(0, 0, 1, 0, 2'b10, 4'h0, 4'd9, 1);
        // leave ONESHOT with done set: counting resumes, done sticks
        step(0, 0, 1, 1, 2'b00, 4'h0, 4'd0, 1);
        step(0, 0, 1, 1, 2'b00, 4'h0, 4'd1, 1);
        // back to ONESHOT while done: en ignored
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd1, 1);
        step(0, 1, 0, 1, 2'b10, 4'd2, 4'd2, 0);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd3, 0);
        // reserved mode behaves as WRAP
        step(0, 1, 0, 1, 2'b11, 4'd9, 4'd9, 0);
        step(0, 0, 1, 1, 2'b11, 4'h0, 4'd0, 0);
        step(0, 0, 1, 0, 2'b11, 4'h0, 4'd9, 0);
        // clamp
        step(0, 1, 1, 1, 2'b00, 4'd13, 4'd9, 0);
        step(0, 1, 0, 1, 2'b00, 4'd10, 4'd9, 0);
        step(0, 1, 0, 1, 2'b00, 4'd15, 4'd9, 0);
        step(0, 1, 0, 1, 2'b00, 4'd4, 4'd4, 0);
        // reset beats load and en
        step(1, 1, 1, 0, 2'b00, 4'd5, 4'd0, 0);
        // reset while done=1
        step(0, 1, 0, 1, 2'b10, 4'd9, 4'd9, 0);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd9, 1);
        step(1, 0, 1, 1, 2'b10, 4'h0, 4'd0, 0);
        step(0, 0, 1, 1, 2'b10, 4'h0, 4'd1, 0);

        @(negedge ck);
        rst = 0; load = 0; en = 0;
        repeat (2) @(posedge ck);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mode_counter
`default_nettype wire
